inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, width of the instruction-memory write address.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  field bundle valid.
REQ-005 SHALL have port in_ready  output  1  encoder can accept a bundle.
REQ-006 SHALL have port in_fmt  input  2  format: 00 load, 01 I-ALU, 10 store, 11 branch.
REQ-007 SHALL have ports in_funct3 (3), in_funct7 (7), in_rd (5), in_rs1 (5), in_rs2 (5), all input, instruction fields.
REQ-008 SHALL have port in_imm  input  32  signed immediate, byte offset for branch.
REQ-009 SHALL have port out_valid  output  1  encoded word available.
REQ-010 SHALL have port out_ready  input  1  consumer (instruction memory writer) accepts word.
REQ-011 SHALL have port out_inst  output  32  encoded instruction word.
REQ-012 SHALL have port out_addr  output  ADDR_W  word address for out_inst.
REQ-013 SHALL have port err_range  output  1  sticky immediate-out-of-range flag.

Function
REQ-014 SHALL accept a bundle on a cycle with in_valid=1 and in_ready=1 (input handshake); SHALL transfer a word on a cycle with out_valid=1 and out_ready=1 (output handshake).
REQ-015 SHALL encode load as {imm[11:0], rs1, funct3, rd, 7'b0000011}.
REQ-016 SHALL encode I-ALU as {funct7, imm[4:0], rs1, funct3, rd, 7'b0010011}.
REQ-017 SHALL encode store as {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011}.
REQ-018 SHALL encode branch as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011}.
REQ-019 SHALL treat as legal: load/store imm in [-2048, 2047]; I-ALU imm in [0, 31]; branch imm even and in [-4096, 4094].
REQ-020 SHALL drop an accepted bundle whose immediate is illegal (not enqueued, address not advanced) and set err_range the cycle after acceptance.
REQ-021 SHALL keep err_range at 1 until reset.
REQ-022 SHALL buffer encoded words in a 2-entry FIFO, registered output, no combinational path from in_* to out_*.
REQ-023 SHALL drive in_ready = 1 when the FIFO holds fewer than 2 entries, 0 when full; there is no pass-through when full, even if out_ready=1.
REQ-024 SHALL present a legal word accepted in cycle N on out_inst with out_valid=1 in cycle N+1 when the FIFO was empty.
REQ-025 SHALL, with one entry held, allow simultaneous input and output handshakes; occupancy stays 1 and FIFO order is preserved.
REQ-026 SHALL hold out_inst and out_valid stable while out_valid=1 and out_ready=0.
REQ-027 SHALL drive out_addr with a write counter that increments by 1 on each output handshake and wraps from 2^ADDR_W-1 to 0.
REQ-028 SHALL drive out_inst = 0 when out_valid=0.

Reset
REQ-029 SHALL, while reset=1 (asynchronously), clear the FIFO and force out_valid=0, out_inst=0, out_addr=0, err_range=0 and in_ready=0.
REQ-030 SHALL drive in_ready=1 on the first clock edge after reset deasserts; a bundle in flight when reset asserts is lost.

Verification
REQ-031 SHALL cover load: fmt=00, rd=5, rs1=2, funct3=010, imm=-4 -> out_inst=0xFFC12283, out_addr=0, one cycle after acceptance.
REQ-032 SHALL cover store then I-ALU: store rs2=6, rs1=2, funct3=010, imm=8 -> 0x00612423 at addr 0; then I-ALU rd=3, rs1=4, funct3=001, funct7=0, imm=5 -> 0x00521193 at addr 1.
REQ-033 SHALL cover branch: rs1=1, rs2=2, funct3=000, imm=-8 -> 0xFE208CE3; then imm=3 -> dropped, err_range=1, out_valid stays 0, out_addr unchanged.
REQ-034 SHALL cover backpressure: out_ready=0, offer 3 legal bundles -> in_ready=0 after 2 accepted; then out_ready=1 -> words out in order at consecutive addresses, third bundle then accepted.
REQ-035 SHALL cover wrap: ADDR_W=2, 5 legal words -> out_addr sequence 0, 1, 2, 3, 0.
REQ-036 SHALL cover reset mid-operation: reset asserted with 2 entries held and err_range=1 -> same cycle out_valid=0, out_addr=0, err_range=0; after release the next word is at addr 0.

Source files
------------

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : inst_encoder
// Description : Packs RV32 load/I-ALU/store/branch field bundles into 32-bit
//               words and queues them in a 2-entry FIFO for an imem writer.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_range
);

  localparam logic [1:0] FMT_LOAD   = 2'b00;
  localparam logic [1:0] FMT_IALU   = 2'b01;
  localparam logic [1:0] FMT_STORE  = 2'b10;
  localparam logic [1:0] FMT_BRANCH = 2'b11;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_IALU    = 7'b0010011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [31:0] word;
  logic        legal;
  logic        fits12;
  logic        fits13;

  // An immediate fits in N signed bits when everything above bit N-2 is a sign copy.
  always_comb begin
    fits12 = (~|in_imm[31:11]) || (&in_imm[31:11]);
    fits13 = (~|in_imm[31:12]) || (&in_imm[31:12]);
    word   = 32'd0;
    legal  = 1'b0;
    case (in_fmt)
      FMT_LOAD: begin
        word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
        legal = fits12;
      end
      FMT_IALU: begin
        word  = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_IALU};
        legal = ~|in_imm[31:5];
      end
      FMT_STORE: begin
        word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
        legal = fits12;
      end
      default: begin
        word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                 in_imm[4:1], in_imm[11], OP_BRANCH};
        legal = fits13 && !in_imm[0];
      end
    endcase
  end

  logic [31:0] mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic        ready_en;
  logic        accept;
  logic        push;
  logic        pop;

  assign in_ready  = ready_en && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_inst  = out_valid ? mem[rd_ptr] : 32'd0;
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign pop       = out_valid && out_ready;

  // ready_en keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0]    <= 32'd0;
      mem[1]    <= 32'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
      ready_en  <= 1'b0;
      out_addr  <= '0;
      err_range <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= word;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        out_addr <= out_addr + ADDR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (accept && !legal) begin
        err_range <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_encoder
// Description : Directed scoreboard bench for inst_encoder (ADDR_W=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_encoder;

  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_fmt = '0;
  logic [2:0]        in_funct3 = '0;
  logic [6:0]        in_funct7 = '0;
  logic [4:0]        in_rd = '0;
  logic [4:0]        in_rs1 = '0;
  logic [4:0]        in_rs2 = '0;
  logic [31:0]       in_imm = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              err_range;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_addr  (out_addr),
    .err_range (err_range)
  );

  int                total = 0;
  int                bad = 0;
  logic [31:0]       sb[$];
  logic [ADDR_W-1:0] exp_addr = '0;
  logic              exp_err = 1'b0;
  logic              rdy_en = 1'b0;
  logic              cur_legal = 1'b0;
  logic [31:0]       cur_word = '0;
  logic              accepted = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_legal(input logic [1:0] fmt, input logic [31:0] imm);
    int s;
    s = $signed(imm);
    case (fmt)
      2'b01:   return (s >= 0) && (s <= 31);
      2'b11:   return (imm[0] == 1'b0) && (s >= -4096) && (s <= 4094);
      default: return (s >= -2048) && (s <= 2047);
    endcase
  endfunction

  function automatic logic [31:0] ref_enc(input logic [1:0] fmt, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [31:0] imm);
    case (fmt)
      2'b00:   return {imm[11:0], rs1, f3, rd, 7'b0000011};
      2'b01:   return {f7, imm[4:0], rs1, f3, rd, 7'b0010011};
      2'b10:   return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      default: return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endcase
  endfunction

  // Samples at the falling edge, settles the handshakes of the coming rising edge.
  task automatic tick();
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy_en && (sb.size() < 2)});
    chk("err_range", {31'd0, err_range}, {31'd0, exp_err});
    if (!out_valid) chk("idle_inst", out_inst, 32'd0);
    accepted = in_valid && in_ready;
    if (out_valid && out_ready && sb.size() != 0) begin
      chk("out_inst", out_inst, sb.pop_front());
      chk("out_addr", {30'd0, out_addr}, {30'd0, exp_addr});
      exp_addr = exp_addr + 2'd1;
    end
    if (accepted) begin
      if (cur_legal) sb.push_back(cur_word);
      else exp_err = 1'b1;
    end
    @(posedge clk);
    #1;
    rdy_en = 1'b1;
  endtask

  task automatic offer(input logic [1:0] fmt, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input logic [31:0] word);
    in_valid  = 1'b1;
    in_fmt    = fmt;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
    cur_word  = word;
    cur_legal = ref_legal(fmt, imm);
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    accepted = 1'b0;
    while (!accepted && n < 20) begin
      tick();
      n++;
    end
    chk("accept_timeout", {31'd0, accepted}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] fmt, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [31:0] word);
    offer(fmt, f3, f7, rd, rs1, rs2, imm, word);
    wait_accept();
  endtask

  task automatic send_ref(input logic [1:0] fmt, input logic [31:0] imm);
    send(fmt, 3'b011, 7'b0100000, 5'd9, 5'd17, 5'd30, imm,
         ref_enc(fmt, 3'b011, 7'b0100000, 5'd9, 5'd17, 5'd30, imm));
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_timeout", sb.size(), 32'd0);
  endtask

  // Reset is raised between edges so the clear is observed before any clock.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_addr", {30'd0, out_addr}, 32'd0);
    chk("rst_err_range", {31'd0, err_range}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    sb.delete();
    exp_addr = '0;
    exp_err  = 1'b0;
    rdy_en   = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] held;
    #2;
    do_reset();

    // Load with negative offset, one-cycle latency into an empty FIFO.
    send(2'b00, 3'b010, 7'd0, 5'd5, 5'd2, 5'd0, -32'sd4, 32'hFFC12283);
    drain();

    do_reset();
    send(2'b10, 3'b010, 7'd0, 5'd0, 5'd2, 5'd6, 32'd8, 32'h00612423);
    send(2'b01, 3'b001, 7'd0, 5'd3, 5'd4, 5'd0, 32'd5, 32'h00521193);
    drain();
    send(2'b11, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd8, 32'hFE208CE3);
    drain();
    send(2'b11, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 32'd0);
    tick();
    tick();
    chk("drop_addr", {30'd0, out_addr}, 32'd3);

    // Immediate range boundaries; five legal words also wrap the 2-bit address.
    do_reset();
    send_ref(2'b00, 32'd2047);
    send_ref(2'b10, -32'sd2048);
    send_ref(2'b01, 32'd31);
    send_ref(2'b11, 32'd4094);
    send_ref(2'b11, -32'sd4096);
    drain();
    chk("wrap_addr", {30'd0, out_addr}, 32'd1);
    send_ref(2'b01, 32'd32);
    tick();
    chk("ialu_32_err", {31'd0, err_range}, 32'd1);
    send_ref(2'b01, -32'sd1);
    send_ref(2'b00, 32'd2048);
    send_ref(2'b10, -32'sd2049);
    send_ref(2'b11, 32'd4096);
    send_ref(2'b11, -32'sd4098);
    tick();
    chk("illegal_addr", {30'd0, out_addr}, 32'd1);

    // Backpressure: third bundle waits until the consumer frees a slot.
    do_reset();
    out_ready = 1'b0;
    send_ref(2'b00, 32'd100);
    send_ref(2'b10, 32'd200);
    held = out_inst;
    offer(2'b01, 3'b101, 7'b0100000, 5'd7, 5'd8, 5'd0, 32'd3,
          ref_enc(2'b01, 3'b101, 7'b0100000, 5'd7, 5'd8, 5'd0, 32'd3));
    repeat (3) tick();
    chk("held_off", {31'd0, accepted}, 32'd0);
    chk("hold_inst", out_inst, held);
    out_ready = 1'b1;
    wait_accept();
    drain();

    // Reset while full and flagged.
    do_reset();
    out_ready = 1'b0;
    send_ref(2'b00, 32'd5000);
    send_ref(2'b00, 32'd12);
    send_ref(2'b11, 32'd16);
    tick();
    chk("pre_reset_err", {31'd0, err_range}, 32'd1);
    do_reset();
    send_ref(2'b10, 32'd44);
    drain();
    chk("post_reset_addr", {30'd0, out_addr}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
